// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM state type, default widths and maximum program length
package loader_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;
    localparam int MAX_LEN    = 16;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: load control, byte stream and instruction-memory bus
//   load_start/load_len   : load request and word count (1..MAX_LEN)
//   byte_in/valid/ready   : program byte stream handshake
//   mem_we/addr/data      : instruction-memory write port
//   cpu_hold/done/err     : CPU fetch hold, completion and rejection pulses
// slave is the loader side, master is the side driving the requests.
interface program_loader_if import loader_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport slave (
        input  load_start, load_len, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_data, cpu_hold, load_done, load_err
    );

    modport master (
        output load_start, load_len, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_data, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/word_assembler.sv
// word_assembler: packs bytes big-endian into a word
//   clk, reset_n : clock, async active-low reset
//   clear        : zero the byte counter and packing register
//   shift_en     : a byte transfers on this edge
//   byte_in      : incoming byte
//   word         : packed word including the byte currently on byte_in
//   word_full    : the byte on byte_in completes the word this edge
module word_assembler #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);
    logic [1:0]        cnt;
    logic [DATA_W-9:0] sh;

    // The completed word is exposed combinationally so the FSM can register
    // it on the same edge as the 4th byte, giving one cycle to mem_we.
    assign word      = {sh, byte_in};
    assign word_full = shift_en && cnt == 2'd3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            sh  <= '0;
        end else if (clear) begin
            cnt <= '0;
            sh  <= '0;
        end else if (shift_en) begin
            cnt <= cnt + 2'd1;
            sh  <= word[DATA_W-9:0];
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams program bytes into instruction memory while holding the CPU
//   clk, reset_n : clock, async active-low reset
//   bus          : program_loader_if slave (request, byte stream, memory port, status)
module program_loader import loader_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic             clk,
    input logic             reset_n,
    program_loader_if.slave bus
);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_LEN);

    state_t            state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   wcnt;
    logic [DATA_W-1:0] word;
    logic              word_full;
    logic              len_ok;

    assign len_ok = bus.load_len != '0 && bus.load_len <= LEN_MAX;

    // The byte counter sits cleared throughout IDLE, so every load starts on a word boundary.
    word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (state == IDLE),
        .shift_en  (bus.byte_valid && bus.byte_ready),
        .byte_in   (bus.byte_in),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            len_q          <= '0;
            wcnt           <= '0;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_data   <= '0;
            bus.cpu_hold   <= 1'b0;
            bus.load_done  <= 1'b0;
            bus.load_err   <= 1'b0;
        end else begin
            bus.mem_we    <= 1'b0;
            bus.load_done <= 1'b0;
            bus.load_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // A request arriving while the error pulse is out is dropped.
                    if (bus.load_start && !bus.load_err) begin
                        if (len_ok) begin
                            len_q          <= bus.load_len;
                            wcnt           <= '0;
                            state          <= COLLECT;
                            bus.byte_ready <= 1'b1;
                            bus.cpu_hold   <= 1'b1;
                        end else begin
                            bus.load_err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (word_full) begin
                        state          <= WRITE;
                        bus.byte_ready <= 1'b0;
                        bus.mem_we     <= 1'b1;
                        bus.mem_addr   <= wcnt[ADDR_W-1:0];
                        bus.mem_data   <= word;
                    end
                end
                WRITE: begin
                    if (wcnt == len_q - 1'b1) begin
                        state         <= DONE;
                        bus.load_done <= 1'b1;
                    end else begin
                        wcnt           <= wcnt + 1'b1;
                        state          <= COLLECT;
                        bus.byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.cpu_hold <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven and randomized checks of program_loader against a word-list model
module tb_program_loader;
    import loader_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int len;
        int gap;
        bit poke;
        int exp_writes;
        bit exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    program_loader_if #(.ADDR_W(4), .DATA_W(32)) bus();

    program_loader #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Observer: records writes and pulses, and checks that every write lands
    // exactly one cycle after a 4th accepted byte of a word.
    logic [35:0] wq[$];
    int done_n, err_n, hold_n, timing_err, hold_err, nx;
    bit pend;

    always @(negedge clk) begin
        if (bus.mem_we !== pend) timing_err++;
        if (bus.mem_we === 1'b1) begin
            wq.push_back({bus.mem_addr, bus.mem_data});
            if (bus.cpu_hold !== 1'b1) hold_err++;
        end
        if (bus.load_done === 1'b1) done_n++;
        if (bus.load_err === 1'b1) err_n++;
        if (bus.cpu_hold === 1'b1) hold_n++;
        else nx = 0;
        pend = 1'b0;
        if (bus.byte_valid && bus.byte_ready) begin
            nx++;
            if (nx % 4 == 0) pend = 1'b1;
        end
    end

    task automatic clear_obs();
        wq.delete();
        done_n = 0;
        err_n = 0;
        hold_n = 0;
        timing_err = 0;
        hold_err = 0;
    endtask

    task automatic start(input int len);
        bus.load_start = 1'b1;
        bus.load_len = 5'(len);
        @(posedge clk);
        #1;
        bus.load_start = 1'b0;
        bus.load_len = 5'($urandom);
    endtask

    task automatic feed(input byte_q_t q, input int gap, input bit poke, output bit ok);
        int i = 0;
        int c = 0;
        bit acc;
        bit poked = 1'b0;
        while (i < q.size() && c < 4000) begin
            bus.byte_valid = ($urandom_range(99) >= gap);
            bus.byte_in = bus.byte_valid ? q[i] : 8'($urandom);
            if (poke && !poked && i == 5) begin
                bus.load_start = 1'b1;
                bus.load_len = 5'd3;
                poked = 1'b1;
            end
            @(negedge clk);
            acc = bus.byte_valid && bus.byte_ready;
            @(posedge clk);
            #1;
            bus.load_start = 1'b0;
            if (acc) i++;
            c++;
        end
        bus.byte_valid = 1'b0;
        ok = (i == q.size());
    endtask

    task automatic do_load(input vec_t v, input string tag);
        byte_q_t q;
        logic [35:0] exp[$];
        int nw;
        bit ok;
        clear_obs();
        nw = (v.len >= 1 && v.len <= MAX_LEN) ? v.len : 0;
        for (int i = 0; i < 4 * nw; i++) q.push_back(8'($urandom));
        for (int w = 0; w < nw; w++)
            exp.push_back({4'(w), q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]});
        start(v.len);
        feed(q, v.gap, v.poke, ok);
        check({tag, " feed_done"}, ok, 1);
        for (int c = 0; c < 50 && bus.cpu_hold; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " writes"}, wq.size(), v.exp_writes);
        for (int w = 0; w < nw && w < wq.size(); w++)
            check($sformatf("%s word%0d", tag, w), wq[w], exp[w]);
        check({tag, " done_pulses"}, done_n, v.exp_err ? 0 : 1);
        check({tag, " err_pulses"}, err_n, v.exp_err ? 1 : 0);
        check({tag, " hold_seen"}, hold_n > 0, !v.exp_err);
        check({tag, " we_timing"}, timing_err, 0);
        check({tag, " hold_during_we"}, hold_err, 0);
        check({tag, " idle_hold"}, bus.cpu_hold, 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " we"}, bus.mem_we, 0);
        check({tag, " ready"}, bus.byte_ready, 0);
        check({tag, " hold"}, bus.cpu_hold, 0);
        check({tag, " done"}, bus.load_done, 0);
        check({tag, " err"}, bus.load_err, 0);
        check({tag, " addr"}, bus.mem_addr, 0);
        check({tag, " data"}, bus.mem_data, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[$];
        logic [7:0] b40[4];
        byte_q_t q6;
        bit ok;

        vecs = '{
            '{1,  0,  0, 1,  0},
            '{0,  0,  0, 0,  1},
            '{17, 0,  0, 0,  1},
            '{31, 0,  0, 0,  1},
            '{2,  30, 0, 2,  0},
            '{3,  20, 1, 3,  0},
            '{16, 40, 0, 16, 0},
            '{5,  60, 0, 5,  0},
            '{16, 0,  0, 16, 0}
        };

        bus.load_start = 1'b0;
        bus.load_len = '0;
        bus.byte_in = '0;
        bus.byte_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_cleared("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single word, back to back, cycle by cycle.
        b40 = '{8'h20, 8'h08, 8'h00, 8'h05};
        start(1);
        @(negedge clk);
        check("w1 ready", bus.byte_ready, 1);
        check("w1 hold", bus.cpu_hold, 1);
        for (int i = 0; i < 4; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_in = b40[i];
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;
        @(negedge clk);
        check("w1 we", bus.mem_we, 1);
        check("w1 addr", bus.mem_addr, 0);
        check("w1 data", bus.mem_data, 32'h20080005);
        check("w1 ready_off", bus.byte_ready, 0);
        @(negedge clk);
        check("w1 we_off", bus.mem_we, 0);
        check("w1 done", bus.load_done, 1);
        check("w1 hold_done", bus.cpu_hold, 1);
        @(negedge clk);
        check("w1 done_off", bus.load_done, 0);
        check("w1 hold_off", bus.cpu_hold, 0);
        check("w1 data_held", bus.mem_data, 32'h20080005);

        // An error pulse swallows any start presented during it.
        clear_obs();
        bus.load_start = 1'b1;
        bus.load_len = 5'd0;
        @(posedge clk);
        #1 bus.load_len = 5'd2;
        @(posedge clk);
        #1 bus.load_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("err_block pulses", err_n, 1);
        check("err_block hold", hold_n, 0);
        check("err_block writes", wq.size(), 0);

        foreach (vecs[k]) do_load(vecs[k], $sformatf("vec%0d", k));

        // Reset after 6 bytes of a 2-word load.
        clear_obs();
        for (int i = 0; i < 6; i++) q6.push_back(8'($urandom));
        start(2);
        feed(q6, 0, 0, ok);
        check("rst feed_done", ok, 1);
        reset_n = 1'b0;
        #1 check_cleared("rst_mid");
        check("rst writes", wq.size(), 1);
        if (wq.size() > 0) check("rst word0", wq[0], {4'd0, q6[0], q6[1], q6[2], q6[3]});
        @(posedge clk);
        #1 reset_n = 1'b1;
        do_load('{1, 25, 0, 1, 0}, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
